// File: rtl/pwm_bank.sv
// Memory-mapped bank of PWM generators with a shared prescaler and period counter.
// Ports: clk, reset_n, wr_en/wr_addr/wr_data, rd_en/rd_addr -> rd_data/rd_hit, pwm_out, wrap_pulse.
module pwm_bank #(
   parameter int                   NUM_CHANNELS = 4,
   parameter int                   DATA_BITS    = 8,
   parameter int                   ADDR_BITS    = 8,
   parameter logic [ADDR_BITS-1:0] BASE_ADDR    = 8'hF0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    wr_en,
   input  logic [ADDR_BITS-1:0]    wr_addr,
   input  logic [DATA_BITS-1:0]    wr_data,
   input  logic                    rd_en,
   input  logic [ADDR_BITS-1:0]    rd_addr,
   output logic [DATA_BITS-1:0]    rd_data,
   output logic                    rd_hit,
   output logic [NUM_CHANNELS-1:0] pwm_out,
   output logic                    wrap_pulse
);

   localparam logic [ADDR_BITS-1:0] WIN = ADDR_BITS'(4 + NUM_CHANNELS);

   logic                    en_q, en_d;
   logic [DATA_BITS-1:0]    pre_q, pre_d;
   logic [DATA_BITS-1:0]    per_sh_q, per_sh_d;
   logic [DATA_BITS-1:0]    per_act_q, per_act_d;
   logic [NUM_CHANNELS-1:0] chen_q, chen_d;
   logic [DATA_BITS-1:0]    cmp_sh_q  [NUM_CHANNELS];
   logic [DATA_BITS-1:0]    cmp_sh_d  [NUM_CHANNELS];
   logic [DATA_BITS-1:0]    cmp_act_q [NUM_CHANNELS];
   logic [DATA_BITS-1:0]    cmp_act_d [NUM_CHANNELS];
   logic [DATA_BITS-1:0]    pre_cnt_q, pre_cnt_d;
   logic [DATA_BITS-1:0]    cnt_q, cnt_d;
   logic [NUM_CHANNELS-1:0] pwm_q, pwm_d;
   logic                    wrap_q, wrap_d;
   logic [DATA_BITS-1:0]    rd_data_q, rd_data_d;
   logic                    rd_hit_q, rd_hit_d;

   logic [ADDR_BITS-1:0]    wr_off, rd_off;
   logic                    wr_hit, rd_in;
   logic                    pre_wr, force_upd;
   logic                    tick, wrap, load;
   logic [DATA_BITS-1:0]    rd_val;

   assign wr_off = wr_addr - BASE_ADDR;
   assign rd_off = rd_addr - BASE_ADDR;
   assign wr_hit = wr_en && (wr_off < WIN);
   assign rd_in  = rd_off < WIN;

   // Register writes into the configuration and shadow registers
   always_comb begin
      en_d      = en_q;
      pre_d     = pre_q;
      per_sh_d  = per_sh_q;
      chen_d    = chen_q;
      pre_wr    = 1'b0;
      force_upd = 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         cmp_sh_d[i] = cmp_sh_q[i];
      end
      if (wr_hit) begin
         if (wr_off == ADDR_BITS'(0)) begin
            en_d      = wr_data[0];
            force_upd = wr_data[1];
         end
         if (wr_off == ADDR_BITS'(1)) begin
            pre_d  = wr_data;
            pre_wr = 1'b1;
         end
         if (wr_off == ADDR_BITS'(2)) per_sh_d = wr_data;
         if (wr_off == ADDR_BITS'(3)) chen_d = wr_data[NUM_CHANNELS-1:0];
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (wr_off == ADDR_BITS'(4 + i)) cmp_sh_d[i] = wr_data;
         end
      end
   end

   // Prescaler, period counter and shadow-to-active transfer
   always_comb begin
      tick = en_q && (pre_cnt_q == pre_q);
      // >= keeps the counter bounded even if the active period shrank
      wrap = tick && (cnt_q >= per_act_q);

      if (!en_q || pre_wr || force_upd) pre_cnt_d = '0;
      else if (tick)                    pre_cnt_d = '0;
      else                              pre_cnt_d = pre_cnt_q + 1'b1;

      if (!en_q || force_upd) cnt_d = '0;
      else if (wrap)          cnt_d = '0;
      else if (tick)          cnt_d = cnt_q + 1'b1;
      else                    cnt_d = cnt_q;

      // Loading from the _d shadows lets a write in the wrap cycle land directly
      load      = wrap || !en_q || force_upd;
      per_act_d = load ? per_sh_d : per_act_q;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         cmp_act_d[i] = load ? cmp_sh_d[i] : cmp_act_q[i];
         pwm_d[i]     = en_q && chen_q[i] && (cnt_q < cmp_act_q[i]);
      end
      wrap_d = wrap;
   end

   // Readback returns shadow values; FORCE_UPD always reads 0
   always_comb begin
      rd_val = '0;
      if (rd_off == ADDR_BITS'(0)) rd_val[0] = en_q;
      if (rd_off == ADDR_BITS'(1)) rd_val = pre_q;
      if (rd_off == ADDR_BITS'(2)) rd_val = per_sh_q;
      if (rd_off == ADDR_BITS'(3)) rd_val[NUM_CHANNELS-1:0] = chen_q;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (rd_off == ADDR_BITS'(4 + i)) rd_val = cmp_sh_q[i];
      end
      rd_hit_d  = rd_en && rd_in;
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = rd_in ? rd_val : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         en_q      <= 1'b0;
         pre_q     <= '0;
         per_sh_q  <= '1;
         per_act_q <= '1;
         chen_q    <= '0;
         pre_cnt_q <= '0;
         cnt_q     <= '0;
         pwm_q     <= '0;
         wrap_q    <= 1'b0;
         rd_data_q <= '0;
         rd_hit_q  <= 1'b0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            cmp_sh_q[i]  <= '0;
            cmp_act_q[i] <= '0;
         end
      end else begin
         en_q      <= en_d;
         pre_q     <= pre_d;
         per_sh_q  <= per_sh_d;
         per_act_q <= per_act_d;
         chen_q    <= chen_d;
         pre_cnt_q <= pre_cnt_d;
         cnt_q     <= cnt_d;
         pwm_q     <= pwm_d;
         wrap_q    <= wrap_d;
         rd_data_q <= rd_data_d;
         rd_hit_q  <= rd_hit_d;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            cmp_sh_q[i]  <= cmp_sh_d[i];
            cmp_act_q[i] <= cmp_act_d[i];
         end
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_hit     = rd_hit_q;
   assign pwm_out    = pwm_q;
   assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: register readback, duty/period,
// glitch-free updates, disable, force update and mid-run reset.
module tb_pwm_bank;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       rd_hit;
   logic [3:0] pwm_out;
   logic       wrap_pulse;

   int n_chk  = 0;
   int n_fail = 0;
   int hi [4];
   int wr_cnt;
   logic [8:0] sb [$];

   localparam logic [7:0] B = 8'hF0;

   pwm_bank dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_hit     (rd_hit),
      .pwm_out    (pwm_out),
      .wrap_pulse (wrap_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 4; i++) hi[i] = 0;
      wr_cnt = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
      wr_cnt += int'(wrap_pulse);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] d,
                     input logic h);
      logic [8:0] e;
      rd_en   = 1'b1;
      rd_addr = a;
      sb.push_back({h, d});
      step();
      rd_en   = 1'b0;
      e = sb.pop_front();
      chk("rd_data", rd_data, e[7:0]);
      chk("rd_hit", rd_hit, e[8]);
   endtask

   task automatic sync_wrap();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!wrap_pulse && n < 100);
      if (!wrap_pulse) chk("wrap_timeout", 0, 1);
   endtask

   task automatic run(input int n);
      clr();
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int n;
      logic [7:0] exp_rst [8];
      exp_rst = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      reset_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      clr();
      step(); step();
      chk("rst_pwm", pwm_out, 0);
      chk("rst_wrap", wrap_pulse, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_hit", rd_hit, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) rd(B + 8'(i), exp_rst[i], 1'b1);

      // 30% duty, 10-clock period
      wr(B + 2, 8'd9);
      wr(B + 1, 8'd0);
      wr(B + 4, 8'd3);
      wr(B + 3, 8'h01);
      wr(B + 0, 8'h01);
      sync_wrap();
      run(20);
      chk("p10_hi0", hi[0], 6);
      chk("p10_hi1", hi[1], 0);
      chk("p10_wraps", wr_cnt, 2);

      // prescaled 8-clock period on channel 1
      wr(B + 1, 8'd1);
      wr(B + 2, 8'd3);
      wr(B + 5, 8'd2);
      wr(B + 3, 8'h02);
      sync_wrap();
      sync_wrap();
      run(8);
      chk("p8_hi1", hi[1], 4);
      chk("p8_hi0", hi[0], 0);
      chk("p8_wraps", wr_cnt, 1);

      // mid-period compare write holds old duty until wrap
      wr(B + 1, 8'd0);
      wr(B + 2, 8'd9);
      wr(B + 3, 8'h01);
      sync_wrap();
      sync_wrap();
      clr();
      wr(B + 4, 8'd7);
      rd(B + 4, 8'd7, 1'b1);
      n = 0;
      do begin step(); n++; end while (!wrap_pulse && n < 50);
      chk("mid_old_hi0", hi[0], 3);
      run(10);
      chk("mid_new_hi0", hi[0], 7);

      // compare write landing on the wrap edge applies immediately
      sync_wrap();
      for (int i = 0; i < 9; i++) step();
      wr(B + 4, 8'd5);
      chk("wrapwr_pulse", wrap_pulse, 1);
      run(10);
      chk("wrapwr_hi0", hi[0], 5);
      chk("wrapwr_wraps", wr_cnt, 1);

      // constant low / constant high channels
      wr(B + 6, 8'h00);
      wr(B + 7, 8'hFF);
      wr(B + 3, 8'h0F);
      sync_wrap();
      run(20);
      chk("cmp_hi0", hi[0], 10);
      chk("cmp0_hi2", hi[2], 0);
      chk("cmpff_hi3", hi[3], 20);

      // disable
      wr(B + 0, 8'h00);
      step();
      chk("dis_pwm", pwm_out, 0);
      run(12);
      chk("dis_hi3", hi[3], 0);
      chk("dis_wraps", wr_cnt, 0);

      // out-of-window read
      rd(B - 1, 8'h00, 1'b0);

      // force update restarts the counter
      wr(B + 3, 8'h01);
      wr(B + 0, 8'h01);
      sync_wrap();
      for (int i = 0; i < 6; i++) step();
      wr(B + 0, 8'h03);
      n = 0;
      do begin step(); n++; end while (!wrap_pulse && n < 50);
      chk("force_restart", n, 10);
      rd(B + 0, 8'h01, 1'b1);

      // reset mid-period with write and read in flight
      sync_wrap();
      rd(B + 2, 8'd9, 1'b1);
      chk("pre_rst_pwm0", pwm_out[0], 1);
      reset_n = 1'b0;
      wr_en = 1'b1; wr_addr = B + 2; wr_data = 8'd3;
      rd_en = 1'b1; rd_addr = B + 2;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("mrst_pwm", pwm_out, 0);
      chk("mrst_wrap", wrap_pulse, 0);
      chk("mrst_rd_data", rd_data, 0);
      chk("mrst_rd_hit", rd_hit, 0);
      reset_n = 1'b1;
      rd(B + 2, 8'hFF, 1'b1);
      rd(B + 0, 8'h00, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
